// File: rtl/spi_flash_loader_pkg.sv
// spi_flash_pkg: shared state encoding and flash command constants for the SPI boot loader
package spi_flash_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, FINISH} state_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_DREAD = 8'h3B;
  localparam int DUMMY_CLKS = 8;
endpackage

// File: rtl/spi_flash_loader_if.sv
// spi_flash_loader_if: control, SPI pins and byte stream of the flash loader
interface spi_flash_loader_if #(parameter int ADDR_W = 24, parameter int LEN_W = 16);
  logic Start, Abort;
  logic [ADDR_W-1:0] BaseAddr;
  logic nFCS, FCK, MOSIout, MOSIOE, MOSIin, MISO;
  logic [7:0] DOut;
  logic DValid, DReady;
  logic [LEN_W-1:0] ByteCnt;
  logic Busy, Done;
  modport master (output Start, Abort, BaseAddr, MOSIin, MISO, DReady,
                  input nFCS, FCK, MOSIout, MOSIOE, DOut, DValid, ByteCnt, Busy, Done);
  modport slave (input Start, Abort, BaseAddr, MOSIin, MISO, DReady,
                 output nFCS, FCK, MOSIout, MOSIOE, DOut, DValid, ByteCnt, Busy, Done);
endinterface

// File: rtl/spi_flash_loader_clk_gen.sv
// spi_clk_gen: FCK divider with rise/fall strobes; stall parks FCK low before a rising edge
module spi_clk_gen #(parameter int CLKDIV = 1) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stall,
  output logic fck,
  output logic rise,
  output logic fall,
  output logic low_done
);
  localparam int CW = CLKDIV > 1 ? $clog2(CLKDIV) : 1;
  logic [CW-1:0] cnt;
  logic tc;
  // terminal count decode and edge strobes for the current cycle
  always_comb begin
    tc = cnt == CW'(CLKDIV - 1);
    rise = en && tc && !fck && !stall;
    fall = en && tc && fck;
    low_done = tc && !fck;
  end
  // half-period counter; a stalled rise holds the counter at terminal count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      fck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      fck <= 1'b0;
    end else if (tc && !(stall && !fck)) begin
      cnt <= '0;
      fck <= ~fck;
    end else if (!tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_flash_loader.sv
// spi_flash_loader: SPI flash boot streamer; define SPI_DUAL_READ_EN for dual-output read (0x3B)
module spi_flash_loader
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int LEN_W = 16,
  parameter int LEN_BYTES = 16384,
  parameter int CLKDIV = 1
) (
  input logic C25M,
  input logic RES,
  spi_flash_loader_if.slave bus
);
`ifdef SPI_DUAL_READ_EN
  localparam logic [7:0] RD_CMD = CMD_DREAD;
  localparam int RISES_PER_BYTE = 4;
  localparam bit DUAL = 1'b1;
`else
  localparam logic [7:0] RD_CMD = CMD_READ;
  localparam int RISES_PER_BYTE = 8;
  localparam bit DUAL = 1'b0;
`endif
  if (LEN_BYTES < 1 || 64'(LEN_BYTES) >= (64'd1 << LEN_W)) begin : g_bad_len
    $error("LEN_BYTES must lie in 1..2**LEN_W-1");
  end
  if (CLKDIV < 1 || (ADDR_W != 24 && ADDR_W != 32)) begin : g_bad_cfg
    $error("CLKDIV must be >=1 and ADDR_W 24 or 32");
  end
  state_t state, next;
  logic [5:0] bcnt;
  logic [ADDR_W+7:0] obuf;
  logic [7:0] rx, rx_nxt, dout;
  logic [LEN_W-1:0] byte_cnt;
  logic dvalid, done, fck, rise, fall, low_done;
  logic en, stall, last, data_done, byte_done, start_ok;
  spi_clk_gen #(.CLKDIV(CLKDIV)) u_clk (
    .clk(C25M), .rst(RES), .en(en), .stall(stall),
    .fck(fck), .rise(rise), .fall(fall), .low_done(low_done)
  );
  // phase decode: last rise of the current phase, stall conditions, byte completion
  always_comb begin
    start_ok = state == IDLE && bus.Start && !bus.Abort;
    en = state != IDLE && !bus.Abort;
    last = state == CMD ? bcnt == 6'd7
         : state == ADDR ? bcnt == 6'(ADDR_W - 1)
         : state == DUMMY ? bcnt == 6'(DUMMY_CLKS - 1)
         : bcnt == 6'(RISES_PER_BYTE - 1);
    data_done = byte_cnt == LEN_W'(LEN_BYTES);
    stall = state == FINISH || (state == DATA && (data_done || (last && dvalid && !bus.DReady)));
    byte_done = rise && state == DATA && last;
    rx_nxt = DUAL ? {rx[5:0], bus.MISO, bus.MOSIin} : {rx[6:0], bus.MISO};
  end
  // state register
  always_ff @(posedge C25M or posedge RES)
    if (RES) state <= IDLE;
    else state <= next;
  // next-state: phases advance on the last FCK rise of each phase; Abort returns to IDLE
  always_comb begin
    next = state == IDLE ? (start_ok ? CMD : IDLE)
         : bus.Abort ? IDLE
         : state == CMD ? (rise && last ? ADDR : CMD)
         : state == ADDR ? (rise && last ? (DUAL ? DUMMY : DATA) : ADDR)
         : state == DUMMY ? (rise && last ? DATA : DUMMY)
         : state == DATA ? (data_done && (!dvalid || bus.DReady) ? FINISH : DATA)
         : low_done ? IDLE : FINISH;
  end
  // datapath: rise counter, command/address shifter, byte assembly and output buffer
  always_ff @(posedge C25M or posedge RES)
    if (RES) begin
      bcnt <= '0;
      obuf <= '0;
      rx <= '0;
      dout <= '0;
      dvalid <= 1'b0;
      byte_cnt <= '0;
      done <= 1'b0;
    end else begin
      bcnt <= (next != state || byte_done) ? 6'd0 : bcnt + {5'd0, rise};
      obuf <= start_ok ? {RD_CMD, bus.BaseAddr} : next == IDLE ? '0 : fall ? {obuf[ADDR_W+6:0], 1'b0} : obuf;
      rx <= (rise && state == DATA) ? rx_nxt : rx;
      dout <= byte_done ? rx_nxt : dout;
      dvalid <= (state != IDLE && bus.Abort) ? 1'b0 : byte_done ? 1'b1 : dvalid && !bus.DReady;
      byte_cnt <= start_ok ? '0 : byte_cnt + LEN_W'(byte_done);
      done <= state == FINISH && !bus.Abort && low_done;
    end
  // outputs: chip select, MOSI driver enable and registered stream signals
  always_comb begin
    bus.nFCS = state == IDLE;
    bus.FCK = fck;
    bus.MOSIout = obuf[ADDR_W+7];
    bus.MOSIOE = DUAL ? (state == CMD || state == ADDR) : state != IDLE;
    bus.Busy = state != IDLE;
    bus.DOut = dout;
    bus.DValid = dvalid;
    bus.ByteCnt = byte_cnt;
    bus.Done = done;
  end
endmodule

// File: tb/tb_spi_flash_loader.sv
// tb_spi_flash_loader: scoreboard bench with a behavioural flash model for spi_flash_loader
module tb_spi_flash_loader;
`ifdef SPI_DUAL_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h3B;
  localparam int DSTART = 40;
  localparam int EXP_RISES = 56;
  localparam logic EXP_OE = 1'b0;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int DSTART = 32;
  localparam int EXP_RISES = 64;
  localparam logic EXP_OE = 1'b1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_flash_loader_if #(.ADDR_W(24), .LEN_W(16)) a ();
  spi_flash_loader_if #(.ADDR_W(24), .LEN_W(16)) b ();
  spi_flash_loader #(.ADDR_W(24), .LEN_W(16), .LEN_BYTES(4), .CLKDIV(1)) u_a (.C25M(clk), .RES(rst), .bus(a.slave));
  spi_flash_loader #(.ADDR_W(24), .LEN_W(16), .LEN_BYTES(2), .CLKDIV(3)) u_b (.C25M(clk), .RES(rst), .bus(b.slave));

  int vecs = 0, errs = 0, done_cnt = 0, rc = 0, rise_total = 0, mp;
  logic [31:0] cap;
  logic oe_data;
  logic [7:0] md, e;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] mem(input logic [23:0] ad);
    logic [7:0] t;
    case (ad[1:0])
      2'd0: t = 8'hA5;
      2'd1: t = 8'h5A;
      2'd2: t = 8'h01;
      default: t = 8'hFF;
    endcase
    return t ^ ad[11:4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flash model: capture command/address on FCK rise, shift data out on FCK fall
  always @(negedge a.nFCS) begin
    rc = 0;
    cap = '0;
  end
  always @(posedge a.FCK) if (!a.nFCS) begin
    if (rc < 32) cap = {cap[30:0], a.MOSIout};
    if (rc == DSTART) oe_data = a.MOSIOE;
    rc++;
    rise_total++;
  end
  always @(negedge a.FCK) if (!a.nFCS && rc >= DSTART) begin
    mp = rc - DSTART;
`ifdef SPI_DUAL_READ_EN
    md = mem(cap[23:0] + 24'(mp / 4));
    a.MISO = md[7-2*(mp%4)];
    a.MOSIin = md[6-2*(mp%4)];
`else
    md = mem(cap[23:0] + 24'(mp / 8));
    a.MISO = md[7-(mp%8)];
`endif
  end

  // monitor: pop expected bytes on every accepted transfer, count Done pulses
  always @(negedge clk) begin
    if (a.DValid && a.DReady) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_byte: got %h expected none", a.DOut);
      end else begin
        e = exp_q.pop_front();
        chk("data_byte", a.DOut, e);
      end
    end
    if (a.Done) begin
      done_cnt++;
      chk("done_busy_ncs", {a.Busy, a.nFCS}, 2'b01);
    end
  end

  task automatic start_load(input logic [23:0] base);
    @(posedge clk); #1;
    a.BaseAddr = base;
    a.Start = 1'b1;
    @(posedge clk); #1;
    a.Start = 1'b0;
    chk("start_busy_ncs_oe", {a.Busy, a.nFCS, a.MOSIOE}, 3'b101);
    chk("start_bytecnt_clr", a.ByteCnt, 0);
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    #1;
    chk({tag, "_done"}, done_cnt - d0, 1);
  endtask

  task automatic finish_checks(input logic [23:0] base, input string tag);
    chk({tag, "_cmd"}, cap[31:24], EXP_CMD);
    chk({tag, "_addr"}, cap[23:0], base);
    chk({tag, "_rises"}, rc, EXP_RISES);
    chk({tag, "_data_oe"}, oe_data, EXP_OE);
    chk({tag, "_bytecnt"}, a.ByteCnt, 4);
    chk({tag, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic run_load(input logic [23:0] base, input string tag, input bit poke);
    for (int i = 0; i < 4; i++) exp_q.push_back(mem(base + 24'(i)));
    start_load(base);
    if (poke) begin
      repeat (30) @(posedge clk);
      #1;
      a.BaseAddr = 24'h000130;
      a.Start = 1'b1;
      @(posedge clk); #1;
      a.Start = 1'b0;
    end
    wait_done(tag);
    finish_checks(base, tag);
  endtask

  initial begin
    int d0, c, h, l, snap;
    a.Start = 0; a.Abort = 0; a.BaseAddr = '0; a.DReady = 1; a.MISO = 0; a.MOSIin = 0;
    b.Start = 0; b.Abort = 0; b.BaseAddr = '0; b.DReady = 1; b.MISO = 0; b.MOSIin = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {a.nFCS, a.FCK, a.MOSIout, a.MOSIOE, a.DValid, a.Busy, a.Done}, 7'b1000000);
    chk("rst_dout", a.DOut, 0);
    chk("rst_bytecnt", a.ByteCnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_load(24'h002000, "basic", 1'b0);

    for (int i = 0; i < 4; i++) exp_q.push_back(mem(24'h000130 + 24'(i)));
    start_load(24'h000130);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (a.DValid) break;
    end
    @(posedge clk); #1 a.DReady = 1'b0;
    repeat (34) @(posedge clk);
    snap = rise_total;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_rises", rise_total - snap, 0);
    chk("stall_fck_low", a.FCK, 0);
    chk("stall_valid", a.DValid, 1);
    a.DReady = 1'b1;
    wait_done("bp");
    finish_checks(24'h000130, "bp");

    d0 = done_cnt;
    start_load(24'h002000);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (rc >= 20) break;
    end
    #1 a.Abort = 1'b1;
    @(posedge clk); #1 a.Abort = 1'b0;
    chk("abort_addr_ctl", {a.nFCS, a.FCK, a.Busy, a.DValid}, 4'b1000);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_addr_nodone", done_cnt - d0, 0);
    run_load(24'h002000, "reload", 1'b1);

    a.DReady = 1'b0;
    d0 = done_cnt;
    start_load(24'h002000);
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (a.ByteCnt == 16'd1) break;
    end
    repeat (20) @(posedge clk);
    #1 a.Abort = 1'b1;
    @(posedge clk); #1 a.Abort = 1'b0;
    chk("abort_data_ctl", {a.nFCS, a.FCK, a.Busy, a.DValid}, 4'b1000);
    chk("abort_data_bytecnt", a.ByteCnt, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_data_nodone", done_cnt - d0, 0);
    chk("abort_data_kept", a.ByteCnt, 1);
    a.DReady = 1'b1;

    @(posedge clk); #1;
    a.Start = 1'b1;
    a.Abort = 1'b1;
    @(posedge clk); #1;
    a.Start = 1'b0;
    a.Abort = 1'b0;
    chk("abort_start_idle", {a.Busy, a.nFCS}, 2'b01);

    a.DReady = 1'b0;
    start_load(24'h002000);
    for (int k = 0; k < 500; k++) begin
      @(posedge clk);
      if (rc >= DSTART + 6) break;
    end
    #3 rst = 1'b1;
    #1;
    chk("midrst_ctl", {a.nFCS, a.FCK, a.MOSIout, a.MOSIOE, a.DValid, a.Busy, a.Done}, 7'b1000000);
    chk("midrst_dout", a.DOut, 0);
    chk("midrst_bytecnt", a.ByteCnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a.DReady = 1'b1;
    run_load(24'h000130, "post_rst", 1'b0);

    @(posedge clk); #1;
    b.Start = 1'b1;
    @(posedge clk); #1;
    b.Start = 1'b0;
    @(negedge clk);
    c = 0;
    for (int k = 0; k < 50; k++) begin
      if (b.FCK) break;
      c++;
      @(negedge clk);
    end
    chk("div3_tcss_ge3", c >= 3, 1);
    h = 0;
    for (int k = 0; k < 50; k++) begin
      if (!b.FCK) break;
      h++;
      @(negedge clk);
    end
    chk("div3_high", h, 3);
    l = 0;
    for (int k = 0; k < 50; k++) begin
      if (b.FCK) break;
      l++;
      @(negedge clk);
    end
    chk("div3_low", l, 3);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (b.Done) break;
    end
    chk("div3_done", b.Done, 1);
    chk("div3_bytecnt", b.ByteCnt, 2);

    chk("final_queue", exp_q.size(), 0);
    chk("final_done_count", done_cnt, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
